pmem_arbiter: RTL and testbench



---
 rtl/pmem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_pmem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// pmem_arbiter
//   Shares the single physical-memory port between the I-cache and D-cache
//   controllers. One line-granular request is granted at a time; the
//   winner's command is latched on the grant edge and driven to memory until
//   pmem_resp. The response pulse is routed back only to the winner.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_pmem_read/addr         I-cache line read request
//   i_pmem_rdata/resp        line data / completion back to the I-cache
//   d_pmem_read/write/addr   D-cache line read or writeback request
//   d_pmem_wdata             D-cache writeback line
//   d_pmem_rdata/resp        line data / completion back to the D-cache
//   pmem_read/write/addr     command to main memory (registered)
//   pmem_wdata               write line to main memory (registered)
//   pmem_rdata/resp          data / completion from main memory
//
// Configuration
//   PMEM_ARB_RR_EN  defined:   simultaneous requests alternate using last_grant
//                   undefined: fixed priority, the D-cache wins every tie
module pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_addr,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_addr,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;

  logic                i_req_s;
  logic                d_req_s;
  logic                tie_to_i_s;

  assign i_req_s = i_pmem_read;
  // A read and write raised together is illegal; it is served as a write.
  assign d_req_s = d_pmem_read | d_pmem_write;

`ifdef PMEM_ARB_RR_EN
  // last_grant encoding: 1 = D-cache, 0 = I-cache
  logic last_grant_q, last_grant_d;
  // A tie goes to whichever cache was not granted last.
  assign tie_to_i_s = last_grant_q;
`else
  assign tie_to_i_s = 1'b0;
`endif

  // Next-state, grant arbitration and command latch update.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
`ifdef PMEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (d_req_s && !(i_req_s && tie_to_i_s)) begin
          state_d = SERVE_D;
          addr_d  = d_pmem_addr;
          wdata_d = d_pmem_wdata;
          wr_d    = d_pmem_write;
          rd_d    = ~d_pmem_write;
`ifdef PMEM_ARB_RR_EN
          last_grant_d = 1'b1;
`endif
        end else if (i_req_s) begin
          // wdata is irrelevant for a read; keep the last latched line.
          state_d = SERVE_I;
          addr_d  = i_pmem_addr;
          rd_d    = 1'b1;
          wr_d    = 1'b0;
`ifdef PMEM_ARB_RR_EN
          last_grant_d = 1'b0;
`endif
        end else begin
          // No request: stay idle, pmem_resp here is ignored.
          state_d = IDLE;
        end
      end
      SERVE_I, SERVE_D: begin
        // Requester input changes are ignored; only pmem_resp ends the
        // transaction, and a forced IDLE cycle follows every completion.
        if (pmem_resp) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  // State and command latch registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {LINE_W{1'b0}};
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

`ifdef PMEM_ARB_RR_EN
  // Round-robin history, reset to favour the I-cache on the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Command outputs come straight from the latches, so they are glitch-free
  // and stable for the whole transaction.
  assign pmem_read  = rd_q;
  assign pmem_write = wr_q;
  assign pmem_addr  = addr_q;
  assign pmem_wdata = wdata_q;

  // Read data is shared; it is only meaningful alongside the matching resp.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  // Completion is a same-cycle pass-through of pmem_resp to the winner only.
  // During reset an outstanding response is dropped.
  assign i_pmem_resp = ~rst & pmem_resp & (state_q == SERVE_I);
  assign d_pmem_resp = ~rst & pmem_resp & (state_q == SERVE_D);

endmodule

// File: tb/tb_pmem_arbiter.sv
module tb_pmem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk;
  logic              rst;
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_addr;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_addr;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_addr(i_pmem_addr),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_addr(d_pmem_addr), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              is_d;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } txn_t;

  txn_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic last_g_m = 1'b1;   // model of round-robin history, 1 = D

  task automatic check_val(input string tag, input logic [LINE_W-1:0] act,
                           input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_txn(input logic is_d, input logic wr,
                          input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wdata);
    txn_t t;
    t.is_d  = is_d;
    t.wr    = wr;
    t.addr  = addr;
    t.wdata = wdata;
    exp_q.push_back(t);
    last_g_m = is_d;
  endtask

  // Memory responder: waits (bounded) for a command, checks it against the
  // scoreboard head for lat cycles, pulses pmem_resp, checks the routed
  // response, then drops the winner's request as a requester would.
  task automatic mem_serve(input int lat, input logic [LINE_W-1:0] rd, output int waited);
    txn_t e;
    waited = 0;
    while (!(pmem_read | pmem_write) && waited < 20) begin
      step();
      waited++;
    end
    check_val("cmd_seen", {255'd0, pmem_read | pmem_write}, 256'd1);
    if (exp_q.size() == 0) begin
      check_val("sb_nonempty", 256'd0, 256'd1);
    end else begin
      e = exp_q.pop_front();
      for (int c = 0; c < lat; c++) begin
        check_val("pmem_read",  {255'd0, pmem_read},  {255'd0, ~e.wr});
        check_val("pmem_write", {255'd0, pmem_write}, {255'd0, e.wr});
        check_val("pmem_addr",  {224'd0, pmem_addr},  {224'd0, e.addr});
        if (e.wr) check_val("pmem_wdata", pmem_wdata, e.wdata);
        check_val("early_resp", {254'd0, i_pmem_resp, d_pmem_resp}, 256'd0);
        step();
      end
      pmem_resp  = 1'b1;
      pmem_rdata = rd;
      #1;
      check_val("resp_cmd_held", {255'd0, pmem_read | pmem_write}, 256'd1);
      check_val("resp_route", {254'd0, i_pmem_resp, d_pmem_resp},
                e.is_d ? 256'd1 : 256'd2);
      if (!e.wr) begin
        check_val("rdata", e.is_d ? d_pmem_rdata : i_pmem_rdata, rd);
      end
      step();
      pmem_resp = 1'b0;
      if (e.is_d) begin
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
      end else begin
        i_pmem_read = 1'b0;
      end
      check_val("post_resp_idle", {254'd0, pmem_read, pmem_write}, 256'd0);
    end
  endtask

  logic [LINE_W-1:0] pat_a5;
  logic [LINE_W-1:0] pat_rd;
  int                w;
  logic              first_d;

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_rd = {8{32'hDEAD_BEEF}};
    rst = 1'b1;
    i_pmem_read = 1'b0; i_pmem_addr = 32'd0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_addr = 32'd0; d_pmem_wdata = 256'd0;
    pmem_rdata = 256'd0; pmem_resp = 1'b0;
    repeat (3) step();
    // reset state
    check_val("rst_cmd", {254'd0, pmem_read, pmem_write}, 256'd0);
    check_val("rst_addr", {224'd0, pmem_addr}, 256'd0);
    check_val("rst_wdata", pmem_wdata, 256'd0);
    check_val("rst_resp", {254'd0, i_pmem_resp, d_pmem_resp}, 256'd0);
    rst = 1'b0;
    step();

    // 1: single I read, response after 5 command cycles
    i_pmem_read = 1'b1; i_pmem_addr = 32'h0000_1000;
    push_txn(1'b0, 1'b0, 32'h0000_1000, 256'd0);
    check_val("t1_no_cmd_yet", {255'd0, pmem_read}, 256'd0);
    mem_serve(5, pat_rd, w);
    check_val("t1_latency", w, 256'd1);

    // 2: D writeback
    step();
    d_pmem_write = 1'b1; d_pmem_addr = 32'h0000_2040; d_pmem_wdata = pat_a5;
    push_txn(1'b1, 1'b1, 32'h0000_2040, pat_a5);
    mem_serve(3, 256'd0, w);
    check_val("t2_latency", w, 256'd1);

    // 3: tie between I and D reads, twice
    for (int r = 0; r < 2; r++) begin
      step();
      i_pmem_read = 1'b1; i_pmem_addr = 32'h0000_3000 + r;
      d_pmem_read = 1'b1; d_pmem_addr = 32'h0000_4000 + r;
`ifdef PMEM_ARB_RR_EN
      first_d = ~last_g_m;
`else
      first_d = 1'b1;
`endif
      if (first_d) begin
        push_txn(1'b1, 1'b0, 32'h0000_4000 + r, 256'd0);
        push_txn(1'b0, 1'b0, 32'h0000_3000 + r, 256'd0);
      end else begin
        push_txn(1'b0, 1'b0, 32'h0000_3000 + r, 256'd0);
        push_txn(1'b1, 1'b0, 32'h0000_4000 + r, 256'd0);
      end
      mem_serve(2, {8{32'h1111_0000 + r}}, w);
      mem_serve(2, {8{32'h2222_0000 + r}}, w);
      check_val("t3_idle_gap", w, 256'd1);
    end

    // 4: D drops request and changes address mid-transaction
    step();
    d_pmem_read = 1'b1; d_pmem_addr = 32'h0000_5000;
    push_txn(1'b1, 1'b0, 32'h0000_5000, 256'd0);
    step();
    d_pmem_read = 1'b0; d_pmem_addr = 32'h0000_6000;
    mem_serve(3, {8{32'h5A5A_5A5A}}, w);
    step();
    check_val("t4_no_rearb", {254'd0, pmem_read, pmem_write}, 256'd0);

    // 5: reset two cycles into SERVE_I, then a stray response
    i_pmem_read = 1'b1; i_pmem_addr = 32'h0000_7000;
    step();
    step();
    check_val("t5_serving", {255'd0, pmem_read}, 256'd1);
    rst = 1'b1; i_pmem_read = 1'b0;
    step();
    check_val("t5_rst_cmd", {254'd0, pmem_read, pmem_write}, 256'd0);
    check_val("t5_rst_addr", {224'd0, pmem_addr}, 256'd0);
    rst = 1'b0;
    step();
    pmem_resp = 1'b1;
    #1;
    check_val("t5_stray_resp", {254'd0, i_pmem_resp, d_pmem_resp}, 256'd0);
    step();
    pmem_resp = 1'b0;
    check_val("t5_still_idle", {254'd0, pmem_read, pmem_write}, 256'd0);

    // 6: pmem_resp in IDLE with no request
    pmem_resp = 1'b1;
    #1;
    check_val("t6_idle_resp", {254'd0, i_pmem_resp, d_pmem_resp}, 256'd0);
    step();
    pmem_resp = 1'b0;
    check_val("t6_no_cmd", {254'd0, pmem_read, pmem_write}, 256'd0);

    // 7: illegal D read+write is served as a write
    d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_addr = 32'h0000_8000;
    d_pmem_wdata = {16{16'hC3C3}};
    push_txn(1'b1, 1'b1, 32'h0000_8000, {16{16'hC3C3}});
    mem_serve(1, 256'd0, w);

    check_val("sb_drained", exp_q.size(), 256'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
